// File: rtl/riscv_pkg.sv
// Shared RV32 datapath definitions: ALU control codes, M-extension op codes
// and the iterative multiply/divide sequencer state.
package riscv_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] MULDIV_MUL   = 2'b00;
    localparam logic [1:0] MULDIV_MULHU = 2'b01;
    localparam logic [1:0] MULDIV_DIVU  = 2'b10;
    localparam logic [1:0] MULDIV_REMU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } muldiv_state_t;

    // MULHU and REMU both live in hi; MUL and DIVU both live in lo.
    function automatic logic [31:0] muldiv_select(input logic [1:0] op,
                                                  input logic [31:0] hi,
                                                  input logic [31:0] lo);
        return op[0] ? hi : lo;
    endfunction

endpackage

// File: rtl/alu.sv
// 32-bit datapath ALU: add/sub with carry-out (C=1 means no borrow on sub),
// logic ops and set-less-than, plus V/N/Z flags.
import riscv_pkg::*;

module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  alu_control,
    output logic [31:0] sum,
    output logic        c,
    output logic        v,
    output logic        n,
    output logic        z
);

    logic [31:0] b_eff;
    logic [32:0] ext;

    // Subtract is a + ~b + 1 so the carry-out doubles as "no borrow".
    assign b_eff = alu_control[0] ? ~b : b;
    assign ext   = {1'b0, a} + {1'b0, b_eff} + {32'd0, alu_control[0]};
    assign c     = ext[32];
    assign v     = (a[31] == b_eff[31]) && (ext[31] != a[31]);

    always_comb begin
        sum = ext[31:0];
        case (alu_control)
            ALU_ADD, ALU_SUB: sum = ext[31:0];
            ALU_AND:          sum = a & b;
            ALU_OR:           sum = a | b;
            ALU_SLT:          sum = {31'd0, ext[31] ^ v};
            default:          sum = ext[31:0];
        endcase
    end

    assign n = sum[31];
    assign z = (sum == 32'd0);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU: one shift-add or restoring-subtract
// step per clock through the shared ALU, fixed 32-iteration latency.
import riscv_pkg::*;

module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    muldiv_state_t   state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] hi, lo, bq;
    logic [1:0]      opq;

    logic [XLEN-1:0] partial, alu_a, alu_sum, hi_nxt, lo_nxt;
    logic [2:0]      alu_ctrl;
    logic            alu_c, alu_v, alu_n, alu_z;
    logic            flags_unused;

    assign flags_unused = alu_v ^ alu_n ^ alu_z;
    assign partial      = {hi[XLEN-2:0], lo[XLEN-1]};

    alu u_alu (
        .a           (alu_a),
        .b           (bq),
        .alu_control (alu_ctrl),
        .sum         (alu_sum),
        .c           (alu_c),
        .v           (alu_v),
        .n           (alu_n),
        .z           (alu_z)
    );

    always_comb begin
        alu_a    = hi;
        alu_ctrl = ALU_ADD;
        hi_nxt   = hi;
        lo_nxt   = lo;
        if (opq[1]) begin
            alu_a    = partial;
            alu_ctrl = ALU_SUB;
            // hi[31] set means partial already exceeds any 32-bit divisor.
            if (hi[XLEN-1] | alu_c) begin
                hi_nxt = alu_sum;
                lo_nxt = {lo[XLEN-2:0], 1'b1};
            end else begin
                hi_nxt = partial;
                lo_nxt = {lo[XLEN-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            {hi_nxt, lo_nxt} = {alu_c, alu_sum, lo[XLEN-1:1]};
        end else begin
            {hi_nxt, lo_nxt} = {1'b0, hi, lo[XLEN-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            bq     <= '0;
            opq    <= MULDIV_MUL;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        opq   <= op;
                        bq    <= B;
                        hi    <= '0;
                        lo    <= A;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    hi  <= hi_nxt;
                    lo  <= lo_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_ITER) begin
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= muldiv_select(opq, hi_nxt, lo_nxt);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq: fixed latency, each op,
// divide-by-zero, ignored start, back-to-back start and mid-run reset.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Launch one op, verify 32 busy cycles, done on the 33rd, result and hold.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp,
                          input string tag);
        int bad;
        bad = 0;
        @(negedge clk);
        start = 1'b1; op = o; A = a; B = b;
        @(negedge clk);
        start = 1'b0; A = ~a; B = ~b;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check({tag, " busy window"}, 32'(bad), 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " result"}, result, exp);
        @(negedge clk);
        check({tag, " done drops"}, {30'd0, busy, done}, 32'd0);
        check({tag, " result held"}, result, exp);
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; op = 2'b00; A = '0; B = '0;
        repeat (3) @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);
        rst = 1'b0;

        run_op(2'b00, 32'd7, 32'd6, 32'd42, "MUL 7*6");
        run_op(2'b01, 32'd7, 32'd6, 32'd0, "MULHU 7*6");
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max");
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "MUL max");
        run_op(2'b10, 32'd100, 32'd7, 32'd14, "DIVU 100/7");
        run_op(2'b11, 32'd100, 32'd7, 32'd2, "REMU 100/7");
        run_op(2'b10, 32'h8000_0000, 32'd3, 32'h2AAA_AAAA, "DIVU 2^31/3");
        run_op(2'b11, 32'h8000_0000, 32'd3, 32'd2, "REMU 2^31/3");
        run_op(2'b10, 32'd1234, 32'd0, 32'hFFFF_FFFF, "DIVU by 0");
        run_op(2'b11, 32'd1234, 32'd0, 32'd1234, "REMU by 0");
        run_op(2'b10, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, "DIVU by 1");

        // start pulsed mid-run must be ignored; start held in DONE is accepted.
        bad = 0;
        @(negedge clk);
        start = 1'b1; op = 2'b00; A = 32'd7; B = 32'd6;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (i == 3) begin start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7; end
            if (i == 4) start = 1'b0;
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("ignored start busy window", 32'(bad), 32'd0);
        check("ignored start done", {31'd0, done}, 32'd1);
        check("ignored start result", result, 32'd42);
        start = 1'b1; op = 2'b01; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0; A = '0; B = '0;
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            @(negedge clk);
        end
        check("back-to-back busy window", 32'(bad), 32'd0);
        check("back-to-back done", {31'd0, done}, 32'd1);
        check("back-to-back result", result, 32'hFFFF_FFFE);
        @(negedge clk);

        // Reset mid-run discards the operation and clears result.
        @(negedge clk);
        start = 1'b1; op = 2'b10; A = 32'd100; B = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid-run reset busy", {31'd0, busy}, 32'd0);
        check("mid-run reset done", {31'd0, done}, 32'd0);
        check("mid-run reset result", result, 32'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("no done after reset", 32'(bad), 32'd0);

        run_op(2'b00, 32'd7, 32'd6, 32'd42, "MUL after reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
